// File: rtl/uart_rx_framer_if.sv
// AXI-stream style word port carrying received UART words from the framer to its consumer.
// The framer drives the master side; the consumer owns tready.
interface uart_rx_framer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_rx_framer.sv
// Oversampling UART receiver: frames start/data/stop bits from a synchronised serial line
// and holds each received word in a single-entry stream register with framing/overrun flags.
module uart_rx_framer #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rxd,
  input  logic [PRESCALE_W-1:0] prescale,
  uart_rx_framer_if.master      m_axis,
  output logic                  busy,
  output logic                  frame_error,
  output logic                  overrun_error
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  localparam logic [PRESCALE_W-1:0] ONE      = PRESCALE_W'(1);
  localparam logic [3:0]            LAST_BIT = 4'(DATA_WIDTH - 1);

  state_t                  state;
  logic [PRESCALE_W-1:0]   cnt;
  logic [PRESCALE_W-1:0]   pre_q;
  logic [3:0]              bit_idx;
  logic [DATA_WIDTH-1:0]   shreg;

  // Bits arrive LSB first, so shifting in from the top leaves the first bit in bit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      pre_q          <= '0;
      bit_idx        <= '0;
      shreg          <= '0;
      busy           <= 1'b0;
      frame_error    <= 1'b0;
      overrun_error  <= 1'b0;
      m_axis.tdata   <= '0;
      m_axis.tvalid  <= 1'b0;
    end else begin
      frame_error   <= 1'b0;
      overrun_error <= 1'b0;

      if (m_axis.tvalid && m_axis.tready) begin
        m_axis.tvalid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (!rxd) begin
            state <= ST_START;
            pre_q <= prescale;
            cnt   <= (prescale >> 1) - ONE;
            busy  <= 1'b1;
          end
        end

        ST_START: begin
          if (cnt != '0) begin
            cnt <= cnt - ONE;
          end else if (rxd) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            state   <= ST_DATA;
            cnt     <= pre_q - ONE;
            bit_idx <= '0;
          end
        end

        ST_DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - ONE;
          end else begin
            shreg <= {rxd, shreg[DATA_WIDTH-1:1]};
            cnt   <= pre_q - ONE;
            if (bit_idx == LAST_BIT) begin
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end
        end

        // A new word overwrites an unaccepted one; only a handshake this cycle avoids overrun.
        ST_STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - ONE;
          end else if (rxd) begin
            state         <= ST_IDLE;
            busy          <= 1'b0;
            m_axis.tdata  <= shreg;
            m_axis.tvalid <= 1'b1;
            if (m_axis.tvalid && !m_axis.tready) begin
              overrun_error <= 1'b1;
            end
          end else begin
            state       <= ST_BREAK;
            frame_error <= 1'b1;
          end
        end

        ST_BREAK: begin
          if (rxd) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
